// File: rtl/spectrum_analyzer_axil_regs_pkg.sv
// Shared definitions for the spectrum analyzer AXI4-Lite register block:
// register offsets, spectrum window base, response codes and read FSM states.
package spectrum_analyzer_pkg;

  localparam logic [31:0] REG_CTRL      = 32'h0000_0000;
  localparam logic [31:0] REG_STATUS    = 32'h0000_0004;
  localparam logic [31:0] REG_FRAME_CNT = 32'h0000_0008;
  localparam logic [31:0] REG_IRQ_EN    = 32'h0000_000C;
  localparam logic [31:0] REG_ID        = 32'h0000_0010;
  localparam logic [31:0] WIN_BASE      = 32'h0000_1000;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [31:0] ID_VALUE_DEFAULT = 32'h5341_0001;

  typedef enum logic [2:0] {
    RD_IDLE    = 3'd0,
    RD_REG     = 3'd1,
    RD_RAM     = 3'd2,
    RD_RAMWAIT = 3'd3,
    RD_RESP    = 3'd4
  } rd_state_t;

  // Byte address to word address: the two low bits never select anything.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/spectrum_analyzer_axil_regs_if.sv
// AXI4-Lite bus bundle between the PS general-purpose master and the
// spectrum analyzer register block.
interface spectrum_analyzer_axil_regs_if #(
  parameter int ADDR_WIDTH = 13
) ();
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/spectrum_analyzer_axil_regs_wr_hold.sv
// AW/W holding-register pair. Each channel is accepted on its own; the pair
// is released by the parent's commit strobe once both halves are present.
module axil_wr_hold #(
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic                  commit,
  output logic                  pair_full,
  output logic [ADDR_WIDTH-1:0] awaddr_q,
  output logic [31:0]           wdata_q,
  output logic [3:0]            wstrb_q
);

  logic aw_full;
  logic w_full;
  logic aw_full_next;
  logic w_full_next;

  // Occupancy of each holding register: filled on handshake, emptied on commit.
  always_comb begin
    aw_full_next = aw_full;
    w_full_next  = w_full;
    if (commit) begin
      aw_full_next = 1'b0;
      w_full_next  = 1'b0;
    end else begin
      if (awvalid && awready) begin
        aw_full_next = 1'b1;
      end else begin
        aw_full_next = aw_full;
      end
      if (wvalid && wready) begin
        w_full_next = 1'b1;
      end else begin
        w_full_next = w_full;
      end
    end
  end

  // Occupancy flags and registered readies (readies stay low during reset).
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      awready <= 1'b0;
      wready  <= 1'b0;
    end else begin
      aw_full <= aw_full_next;
      w_full  <= w_full_next;
      awready <= !aw_full_next;
      wready  <= !w_full_next;
    end
  end

  // Capture address and data/strobe on their respective handshakes.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      awaddr_q <= '0;
      wdata_q  <= 32'h0000_0000;
      wstrb_q  <= 4'h0;
    end else begin
      if (awvalid && awready) begin
        awaddr_q <= awaddr;
      end
      if (wvalid && wready) begin
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
    end
  end

  assign pair_full = aw_full && w_full;

endmodule

// File: rtl/spectrum_analyzer_axil_regs.sv
// AXI4-Lite register block for the spectrum analyzer: CTRL/STATUS/FRAME_CNT/ID
// registers plus a read-only window onto the magnitude-spectrum RAM.
// Optional feature macro SA_AXIL_IRQ_EN adds the IRQ_EN register and irq port.
module spectrum_analyzer_axil_regs
  import spectrum_analyzer_pkg::*;
#(
  parameter int          ADDR_WIDTH = 13,
  parameter int          BIN_COUNT  = 1024,
  parameter logic [31:0] ID_VALUE   = ID_VALUE_DEFAULT
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  spectrum_analyzer_axil_regs_if.slave s_axi,
  output logic                         ctrl_enable,
  output logic                         ctrl_clear,
  input  logic                         frame_done,
  input  logic                         busy,
  output logic [$clog2(BIN_COUNT)-1:0] ram_raddr,
  output logic                         ram_ren,
  input  logic [31:0]                  ram_rdata
`ifdef SA_AXIL_IRQ_EN
  , output logic                       irq
`endif
);

  localparam int          RAM_AW  = $clog2(BIN_COUNT);
  localparam logic [31:0] WIN_END = WIN_BASE + 32'(4 * BIN_COUNT);

  // ---------------- write path ----------------
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic                  pair_full;
  logic                  commit;
  logic                  b_valid;
  logic [1:0]            b_resp;
  logic [31:0]           wr_word;
  logic                  wr_ctrl;
  logic                  wr_status;
  logic                  wr_irqen;
  logic                  wr_err;
  logic                  ctrl_wr;
  logic                  w1c;
  logic                  sticky;
  logic [31:0]           frame_cnt;
  logic                  irq_en;
  logic                  unused_bits;

  axil_wr_hold #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_hold (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .awaddr   (s_axi.awaddr),
    .awvalid  (s_axi.awvalid),
    .awready  (s_axi.awready),
    .wdata    (s_axi.wdata),
    .wstrb    (s_axi.wstrb),
    .wvalid   (s_axi.wvalid),
    .wready   (s_axi.wready),
    .commit   (commit),
    .pair_full(pair_full),
    .awaddr_q (awaddr_q),
    .wdata_q  (wdata_q),
    .wstrb_q  (wstrb_q)
  );

  // A held pair commits only when the previous response has been taken.
  assign commit  = pair_full && !b_valid;
  assign wr_word = word_align(32'(awaddr_q));

  // Write address decode; anything not writable answers SLVERR.
  always_comb begin
    wr_ctrl   = 1'b0;
    wr_status = 1'b0;
    wr_irqen  = 1'b0;
    wr_err    = 1'b1;
    case (wr_word)
      REG_CTRL: begin
        wr_ctrl = 1'b1;
        wr_err  = 1'b0;
      end
      REG_STATUS: begin
        wr_status = 1'b1;
        wr_err    = 1'b0;
      end
`ifdef SA_AXIL_IRQ_EN
      REG_IRQ_EN: begin
        wr_irqen = 1'b1;
        wr_err   = 1'b0;
      end
`endif
      default: wr_err = 1'b1;
    endcase
  end

  assign ctrl_wr = commit && wr_ctrl && wstrb_q[0];
  assign w1c     = commit && wr_status && wstrb_q[0] && wdata_q[0];

  // Only byte 0 of the write data carries register bits.
  assign unused_bits = ^{wdata_q[31:2], wstrb_q[3:1], wr_irqen};

  // Write response: raised the cycle after commit, held until bready.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      b_valid <= 1'b0;
      b_resp  <= RESP_OKAY;
    end else if (commit) begin
      b_valid <= 1'b1;
      b_resp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
    end else if (b_valid && s_axi.bready) begin
      b_valid <= 1'b0;
    end
  end

  assign s_axi.bvalid = b_valid;
  assign s_axi.bresp  = b_resp;

  // CTRL: enable level and one-cycle clear pulse after the committing write.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ctrl_enable <= 1'b0;
      ctrl_clear  <= 1'b0;
    end else begin
      ctrl_clear <= ctrl_wr && wdata_q[1];
      if (ctrl_wr) begin
        ctrl_enable <= wdata_q[0];
      end
    end
  end

  // Sticky done flag and frame counter; clear beats frame_done, which beats W1C.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sticky    <= 1'b0;
      frame_cnt <= 32'h0000_0000;
    end else if (ctrl_clear) begin
      sticky    <= 1'b0;
      frame_cnt <= 32'h0000_0000;
    end else begin
      if (frame_done) begin
        sticky    <= 1'b1;
        frame_cnt <= frame_cnt + 32'd1;
      end else if (w1c) begin
        sticky <= 1'b0;
      end
    end
  end

`ifdef SA_AXIL_IRQ_EN
  // Interrupt enable register and registered level interrupt.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (commit && wr_irqen && wstrb_q[0]) begin
        irq_en <= wdata_q[0];
      end
      irq <= sticky && irq_en;
    end
  end
`else
  assign irq_en = 1'b0;
`endif

  // ---------------- read path ----------------
  rd_state_t             state;
  rd_state_t             state_next;
  logic                  ar_ready;
  logic                  ar_hs;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic [31:0]           rd_word;
  logic [31:0]           rd_mux;
  logic                  rd_err;
  logic [31:0]           r_data;
  logic [1:0]            r_resp;
  logic                  r_valid;

  // True when a byte address falls inside the spectrum window.
  function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a);
    logic [31:0] w;
    w = 32'(a);
    return (w >= WIN_BASE) && (w < WIN_END);
  endfunction

  assign ar_hs = s_axi.arvalid && ar_ready && (state == RD_IDLE);

  // Read FSM next-state: register reads take REG, window reads go via RAM.
  always_comb begin
    state_next = state;
    case (state)
      RD_IDLE: begin
        if (ar_hs) begin
          state_next = in_window(s_axi.araddr) ? RD_RAM : RD_REG;
        end else begin
          state_next = RD_IDLE;
        end
      end
      RD_REG:     state_next = RD_RESP;
      RD_RAM:     state_next = RD_RAMWAIT;
      RD_RAMWAIT: state_next = RD_RESP;
      RD_RESP: begin
        if (s_axi.rready) begin
          state_next = RD_IDLE;
        end else begin
          state_next = RD_RESP;
        end
      end
      default: state_next = RD_IDLE;
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= RD_IDLE;
    end else begin
      state <= state_next;
    end
  end

  assign rd_word = word_align(32'(raddr_q));

  // Register read mux; unmapped addresses read zero with SLVERR.
  always_comb begin
    rd_mux = 32'h0000_0000;
    rd_err = 1'b0;
    case (rd_word)
      REG_CTRL:      rd_mux = {31'd0, ctrl_enable};
      REG_STATUS:    rd_mux = {30'd0, busy, sticky};
      REG_FRAME_CNT: rd_mux = frame_cnt;
`ifdef SA_AXIL_IRQ_EN
      REG_IRQ_EN:    rd_mux = {31'd0, irq_en};
`endif
      REG_ID:        rd_mux = ID_VALUE;
      default: begin
        rd_mux = 32'h0000_0000;
        rd_err = 1'b1;
      end
    endcase
  end

  // Registered read-side outputs: readies, RAM port and the R channel.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ar_ready  <= 1'b0;
      ram_ren   <= 1'b0;
      ram_raddr <= '0;
      raddr_q   <= '0;
      r_valid   <= 1'b0;
      r_data    <= 32'h0000_0000;
      r_resp    <= RESP_OKAY;
    end else begin
      ar_ready <= (state_next == RD_IDLE);
      ram_ren  <= (state_next == RD_RAM);
      r_valid  <= (state_next == RD_RESP);
      if (ar_hs) begin
        raddr_q   <= s_axi.araddr;
        ram_raddr <= s_axi.araddr[RAM_AW+1:2];
      end
      if (state == RD_REG) begin
        r_data <= rd_mux;
        r_resp <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (state == RD_RAMWAIT) begin
        r_data <= ram_rdata;
        r_resp <= RESP_OKAY;
      end
    end
  end

  assign s_axi.arready = ar_ready;
  assign s_axi.rvalid  = r_valid;
  assign s_axi.rdata   = r_data;
  assign s_axi.rresp   = r_resp;

endmodule

// File: tb/tb_spectrum_analyzer_axil_regs.sv
// Directed self-checking bench for spectrum_analyzer_axil_regs.
module tb_spectrum_analyzer_axil_regs;
  logic        aclk;
  logic        aresetn;
  logic        ctrl_enable;
  logic        ctrl_clear;
  logic        frame_done;
  logic        busy;
  logic [9:0]  ram_raddr;
  logic        ram_ren;
  logic [31:0] ram_rdata;
  logic [31:0] mem [0:1023];
`ifdef SA_AXIL_IRQ_EN
  logic        irq;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  spectrum_analyzer_axil_regs_if #(.ADDR_WIDTH(13)) axil ();

  spectrum_analyzer_axil_regs dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .s_axi      (axil.slave),
    .ctrl_enable(ctrl_enable),
    .ctrl_clear (ctrl_clear),
    .frame_done (frame_done),
    .busy       (busy),
    .ram_raddr  (ram_raddr),
    .ram_ren    (ram_ren),
    .ram_rdata  (ram_rdata)
`ifdef SA_AXIL_IRQ_EN
    , .irq      (irq)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Synchronous RAM model, one-cycle read latency.
  always_ff @(posedge aclk) begin
    if (ram_ren) ram_rdata <= mem[ram_raddr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic pulse_fd(input int n);
    repeat (n) begin
      frame_done = 1'b1;
      @(negedge aclk);
      frame_done = 1'b0;
      @(negedge aclk);
    end
  endtask

  // w_lead > 0 presents W that many cycles ahead of AW; fd_at pulses frame_done
  // in the given cycle after the handshake (1 = commit cycle, 2 = clear cycle).
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int w_lead, input int fd_at,
                           output logic [1:0] resp, output int lat, output int clr, output int bcnt);
    lat = 0; clr = 0; bcnt = 0; resp = 2'b11;
    axil.bready = 1'b1;
    if (w_lead > 0) begin
      axil.wdata = data; axil.wstrb = strb; axil.wvalid = 1'b1;
      @(negedge aclk);
      axil.wvalid = 1'b0;
      repeat (w_lead - 1) @(negedge aclk);
    end
    axil.awaddr = addr[12:0]; axil.awvalid = 1'b1;
    if (w_lead == 0) begin
      axil.wdata = data; axil.wstrb = strb; axil.wvalid = 1'b1;
    end
    @(negedge aclk);
    axil.awvalid = 1'b0; axil.wvalid = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      frame_done = (t == fd_at);
      if (axil.bvalid) begin
        if (bcnt == 0) begin
          lat = t; resp = axil.bresp;
        end
        bcnt++;
      end
      if (ctrl_clear) clr++;
      @(negedge aclk);
    end
    frame_done = 1'b0;
    axil.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input int hold,
                          output logic [31:0] data, output logic [1:0] resp, output int lat,
                          output logic stable);
    int t;
    lat = 0; data = 32'hFFFF_FFFF; resp = 2'b11; stable = 1'b0;
    axil.araddr = addr[12:0]; axil.arvalid = 1'b1; axil.rready = 1'b0;
    @(negedge aclk);
    axil.arvalid = 1'b0;
    t = 1;
    while (!axil.rvalid && t < 12) begin
      @(negedge aclk);
      t++;
    end
    if (axil.rvalid) begin
      lat = t; data = axil.rdata; resp = axil.rresp; stable = 1'b1;
    end
    repeat (hold) begin
      @(negedge aclk);
      if (!axil.rvalid || axil.rdata !== data || axil.rresp !== resp) stable = 1'b0;
    end
    axil.rready = 1'b1;
    @(negedge aclk);
    axil.rready = 1'b0;
  endtask

  logic [1:0]  resp;
  logic [31:0] rd;
  logic        st;
  int          lat;
  int          clr;
  int          bcnt;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0000;
    mem[5]    = 32'hDEAD_BEEF;
    mem[1023] = 32'hA5A5_0FF0;
    aresetn = 1'b0; frame_done = 1'b0; busy = 1'b0;
    axil.awaddr = 13'd0; axil.awvalid = 1'b0; axil.wdata = 32'd0; axil.wstrb = 4'd0;
    axil.wvalid = 1'b0; axil.bready = 1'b0; axil.araddr = 13'd0; axil.arvalid = 1'b0;
    axil.rready = 1'b0;
    repeat (3) @(negedge aclk);

    // Reset values
    check_eq("rst_ready", {29'd0, axil.awready, axil.wready, axil.arready}, 32'd0);
    check_eq("rst_valid", {30'd0, axil.bvalid, axil.rvalid}, 32'd0);
    check_eq("rst_rdata", axil.rdata, 32'd0);
    check_eq("rst_resp", {28'd0, axil.bresp, axil.rresp}, 32'd0);
    check_eq("rst_ctrl", {29'd0, ctrl_enable, ctrl_clear, ram_ren}, 32'd0);
    aresetn = 1'b1;
    #1 check_eq("ready_low_at_release", {29'd0, axil.awready, axil.wready, axil.arready}, 32'd0);
    @(negedge aclk);
    check_eq("ready_high_after_release", {29'd0, axil.awready, axil.wready, axil.arready}, 32'd7);

    // ID register
    axi_read(32'h010, 0, rd, resp, lat, st);
    check_eq("id_data", rd, 32'h5341_0001);
    check_eq("id_resp", {30'd0, resp}, 32'd0);
    check_eq("id_lat", lat, 32'd2);

    // CTRL enable + clear pulse
    axi_write(32'h000, 32'h3, 4'hF, 0, 0, resp, lat, clr, bcnt);
    check_eq("ctrl_wr_resp", {30'd0, resp}, 32'd0);
    check_eq("ctrl_wr_lat", lat, 32'd2);
    check_eq("ctrl_clear_cycles", clr, 32'd1);
    check_eq("ctrl_enable", {31'd0, ctrl_enable}, 32'd1);
    axi_read(32'h000, 0, rd, resp, lat, st);
    check_eq("ctrl_read", rd, 32'h1);

    // Frame counting and sticky
    busy = 1'b1;
    pulse_fd(3);
    axi_read(32'h008, 0, rd, resp, lat, st);
    check_eq("frame_cnt_3", rd, 32'd3);
    axi_read(32'h004, 0, rd, resp, lat, st);
    check_eq("status_sticky_busy", rd, 32'h3);
    axi_write(32'h004, 32'h1, 4'hF, 0, 0, resp, lat, clr, bcnt);
    check_eq("status_w1c_resp", {30'd0, resp}, 32'd0);
    busy = 1'b0;
    axi_read(32'h004, 0, rd, resp, lat, st);
    check_eq("status_after_w1c", rd, 32'h0);

    // frame_done in the commit cycle of a W1C: set wins
    pulse_fd(1);
    axi_write(32'h004, 32'h1, 4'hF, 0, 1, resp, lat, clr, bcnt);
    axi_read(32'h004, 0, rd, resp, lat, st);
    check_eq("status_set_wins", rd, 32'h1);
    axi_read(32'h008, 0, rd, resp, lat, st);
    check_eq("frame_cnt_5", rd, 32'd5);

    // Write to RO register
    axi_write(32'h008, 32'h1234, 4'hF, 0, 0, resp, lat, clr, bcnt);
    check_eq("ro_wr_resp", {30'd0, resp}, 32'h2);
    axi_read(32'h008, 0, rd, resp, lat, st);
    check_eq("ro_wr_no_effect", rd, 32'd5);

    // Byte strobes: byte 0 not enabled leaves enable untouched
    axi_write(32'h000, 32'h0, 4'h0, 0, 0, resp, lat, clr, bcnt);
    check_eq("strb0_resp", {30'd0, resp}, 32'd0);
    axi_write(32'h000, 32'h0, 4'hE, 0, 0, resp, lat, clr, bcnt);
    check_eq("strb_enable_kept", {31'd0, ctrl_enable}, 32'd1);

    // Clear coinciding with frame_done: clear wins
    axi_write(32'h000, 32'h2, 4'h1, 0, 2, resp, lat, clr, bcnt);
    check_eq("clear_cycles", clr, 32'd1);
    check_eq("clear_enable_off", {31'd0, ctrl_enable}, 32'd0);
    axi_read(32'h008, 0, rd, resp, lat, st);
    check_eq("clear_frame_cnt", rd, 32'd0);
    axi_read(32'h004, 0, rd, resp, lat, st);
    check_eq("clear_sticky", rd, 32'd0);

    // Spectrum window
    axi_read(32'h1014, 4, rd, resp, lat, st);
    check_eq("ram_bin5", rd, 32'hDEAD_BEEF);
    check_eq("ram_resp", {30'd0, resp}, 32'd0);
    check_eq("ram_lat", lat, 32'd3);
    check_eq("ram_hold_stable", {31'd0, st}, 32'd1);
    axi_read(32'h1FFC, 0, rd, resp, lat, st);
    check_eq("ram_last_bin", rd, 32'hA5A5_0FF0);
    axi_write(32'h1014, 32'h1, 4'hF, 0, 0, resp, lat, clr, bcnt);
    check_eq("ram_wr_resp", {30'd0, resp}, 32'h2);

    // Unmapped read
    axi_read(32'h020, 0, rd, resp, lat, st);
    check_eq("unmapped_data", rd, 32'd0);
    check_eq("unmapped_resp", {30'd0, resp}, 32'h2);
    check_eq("unmapped_lat", lat, 32'd2);

    // W ahead of AW
    axi_write(32'h000, 32'h1, 4'hF, 2, 0, resp, lat, clr, bcnt);
    check_eq("wlead_bcount", bcnt, 32'd1);
    check_eq("wlead_lat", lat, 32'd2);
    check_eq("wlead_enable", {31'd0, ctrl_enable}, 32'd1);

`ifdef SA_AXIL_IRQ_EN
    axi_write(32'h00C, 32'h1, 4'hF, 0, 0, resp, lat, clr, bcnt);
    check_eq("irqen_resp", {30'd0, resp}, 32'd0);
    check_eq("irq_idle", {31'd0, irq}, 32'd0);
    pulse_fd(1);
    check_eq("irq_set", {31'd0, irq}, 32'd1);
    axi_write(32'h004, 32'h1, 4'hF, 0, 0, resp, lat, clr, bcnt);
    check_eq("irq_cleared", {31'd0, irq}, 32'd0);
`else
    axi_read(32'h00C, 0, rd, resp, lat, st);
    check_eq("irqen_absent_resp", {30'd0, resp}, 32'h2);
    axi_write(32'h00C, 32'h1, 4'hF, 0, 0, resp, lat, clr, bcnt);
    check_eq("irqen_absent_wr", {30'd0, resp}, 32'h2);
`endif

    // Reset in the middle of a read drops it
    pulse_fd(2);
    axil.araddr = 13'h010; axil.arvalid = 1'b1;
    @(negedge aclk);
    axil.arvalid = 1'b0;
    aresetn = 1'b0;
    #1 check_eq("midrst_rvalid", {31'd0, axil.rvalid}, 32'd0);
    check_eq("midrst_enable", {31'd0, ctrl_enable}, 32'd0);
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check_eq("midrst_no_resp", {30'd0, axil.rvalid, axil.bvalid}, 32'd0);
    check_eq("midrst_arready", {31'd0, axil.arready}, 32'd1);
    axi_read(32'h008, 0, rd, resp, lat, st);
    check_eq("midrst_frame_cnt", rd, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
